// File: rtl/some_module_core_if.sv
// Control and status bundle for some_module_core.
// The master drives the count controls; the slave (the counter) returns
// the registered count state and the elaborated parameter values.
interface some_module_core_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             wrap;
  logic [15:0]      wrap_cnt;
  logic             param_bit;
  logic [31:0]      param_int;

  modport master (
    output en, clear, load, load_val,
    input  count, wrap, wrap_cnt, param_bit, param_int
  );

  modport slave (
    input  en, clear, load, load_val,
    output count, wrap, wrap_cnt, param_bit, param_int
  );
endinterface

// File: rtl/some_module_core.sv
// Parameter-configured modulo event counter.
// Counts enabled events up (SOME_BIT_PARAM=1) or down (SOME_BIT_PARAM=0)
// over the range 0..T, where T = SOME_OTHER_INT_PARAM. A terminal crossing
// produces a registered one-cycle wrap strobe and bumps a saturating
// 16-bit wrap tally. The elaborated parameters are echoed as constants.
module some_module_core #(
  parameter bit SOME_BIT_PARAM       = 1'b0,
  parameter int SOME_OTHER_INT_PARAM = 0,
  parameter int CNT_W                = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  some_module_core_if.slave    bus
);

  // Terminal must fit in the counter and lie in 0..255.
  generate
    if ((SOME_OTHER_INT_PARAM < 0) || (SOME_OTHER_INT_PARAM > 255) ||
        (CNT_W < 1) ||
        (longint'(SOME_OTHER_INT_PARAM) >= (longint'(1) << CNT_W))) begin : g_bad_param
      $fatal(1, "some_module_core: SOME_OTHER_INT_PARAM out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] T_VAL     = CNT_W'(SOME_OTHER_INT_PARAM);
  localparam logic [CNT_W-1:0] START_VAL = SOME_BIT_PARAM ? '0 : T_VAL;

  logic [CNT_W-1:0] count_reg, count_next;
  logic             wrap_reg,  wrap_next;
  logic [15:0]      wrap_cnt_reg, wrap_cnt_next;
  logic             at_terminal;

  // Crossing point: T when counting up, 0 when counting down.
  assign at_terminal = SOME_BIT_PARAM ? (count_reg == T_VAL) : (count_reg == '0);

  // Next-state selection: clear > load > en > hold.
  always_comb begin
    count_next    = count_reg;
    wrap_next     = 1'b0;
    wrap_cnt_next = wrap_cnt_reg;
    if (bus.clear) begin
      count_next = START_VAL;
    end else if (bus.load) begin
      count_next = (bus.load_val > T_VAL) ? T_VAL : bus.load_val;
    end else if (bus.en) begin
      if (at_terminal) begin
        // Crossing: jump to the opposite end of the range and strobe wrap.
        count_next = SOME_BIT_PARAM ? '0 : T_VAL;
        wrap_next  = 1'b1;
        if (wrap_cnt_reg != 16'hFFFF) begin
          wrap_cnt_next = wrap_cnt_reg + 16'd1;
        end
      end else begin
        count_next = SOME_BIT_PARAM ? (count_reg + 1'b1) : (count_reg - 1'b1);
      end
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg    <= START_VAL;
      wrap_reg     <= 1'b0;
      wrap_cnt_reg <= '0;
    end else begin
      count_reg    <= count_next;
      wrap_reg     <= wrap_next;
      wrap_cnt_reg <= wrap_cnt_next;
    end
  end

  assign bus.count     = count_reg;
  assign bus.wrap      = wrap_reg;
  assign bus.wrap_cnt  = wrap_cnt_reg;
  assign bus.param_bit = SOME_BIT_PARAM;
  assign bus.param_int = 32'(SOME_OTHER_INT_PARAM);

endmodule

// File: tb/tb_some_module_core.sv
// Self-checking bench for some_module_core.
// Three instances: up-counter T=18, down-counter T=18, up-counter T=0.
// A modulo-arithmetic reference model tracks every instance each cycle.
module tb_some_module_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  some_module_core_if #(.CNT_W(8)) if_up ();
  some_module_core_if #(.CNT_W(8)) if_dn ();
  some_module_core_if #(.CNT_W(8)) if_z ();

  some_module_core #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM('h12), .CNT_W(8))
    u_up (.clk(clk), .rst_n(rst_n), .bus(if_up.slave));
  some_module_core #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM('h12), .CNT_W(8))
    u_dn (.clk(clk), .rst_n(rst_n), .bus(if_dn.slave));
  some_module_core #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(0), .CNT_W(8))
    u_z  (.clk(clk), .rst_n(rst_n), .bus(if_z.slave));

  // Bench-side stimulus, indexed 0=up, 1=down, 2=T0
  logic       in_en [3];
  logic       in_clear [3];
  logic       in_load [3];
  logic [7:0] in_lv [3];

  assign if_up.en = in_en[0];  assign if_up.clear = in_clear[0];
  assign if_up.load = in_load[0];  assign if_up.load_val = in_lv[0];
  assign if_dn.en = in_en[1];  assign if_dn.clear = in_clear[1];
  assign if_dn.load = in_load[1];  assign if_dn.load_val = in_lv[1];
  assign if_z.en = in_en[2];   assign if_z.clear = in_clear[2];
  assign if_z.load = in_load[2];   assign if_z.load_val = in_lv[2];

  logic [7:0]  d_count [3];
  logic        d_wrap [3];
  logic [15:0] d_wcnt [3];
  logic        d_pbit [3];
  logic [31:0] d_pint [3];

  assign d_count[0] = if_up.count; assign d_wrap[0] = if_up.wrap; assign d_wcnt[0] = if_up.wrap_cnt;
  assign d_count[1] = if_dn.count; assign d_wrap[1] = if_dn.wrap; assign d_wcnt[1] = if_dn.wrap_cnt;
  assign d_count[2] = if_z.count;  assign d_wrap[2] = if_z.wrap;  assign d_wcnt[2] = if_z.wrap_cnt;
  assign d_pbit[0] = if_up.param_bit; assign d_pint[0] = if_up.param_int;
  assign d_pbit[1] = if_dn.param_bit; assign d_pint[1] = if_dn.param_int;
  assign d_pbit[2] = if_z.param_bit;  assign d_pint[2] = if_z.param_int;

  // Reference model state
  int m_t [3]  = '{18, 18, 0};
  int m_up [3] = '{1, 0, 1};
  int m_count [3];
  int m_wrap [3];
  int m_wcnt [3];

  int checks = 0;
  int errors = 0;

  function automatic int start_of(int i);
    return (m_up[i] != 0) ? 0 : m_t[i];
  endfunction

  // Behavioural update for one clock edge, using the inputs as sampled there
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_count[i] = start_of(i); m_wrap[i] = 0; m_wcnt[i] = 0;
      end else if (in_clear[i]) begin
        m_count[i] = start_of(i); m_wrap[i] = 0;
      end else if (in_load[i]) begin
        m_count[i] = (int'(in_lv[i]) > m_t[i]) ? m_t[i] : int'(in_lv[i]);
        m_wrap[i] = 0;
      end else if (in_en[i]) begin
        if (m_up[i] != 0) begin
          m_wrap[i]  = (m_count[i] == m_t[i]) ? 1 : 0;
          m_count[i] = (m_count[i] + 1) % (m_t[i] + 1);
        end else begin
          m_wrap[i]  = (m_count[i] == 0) ? 1 : 0;
          m_count[i] = (m_count[i] + m_t[i]) % (m_t[i] + 1);
        end
        if (m_wrap[i] != 0 && m_wcnt[i] < 65535) m_wcnt[i]++;
      end else begin
        m_wrap[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_en[i] = 1'b0; in_clear[i] = 1'b0; in_load[i] = 1'b0; in_lv[i] = 8'd0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_count[i] !== 8'(start_of(i))) begin
        errors++; $display("FAIL reset_count inst=%0d got=%0d exp=%0d", i, d_count[i], start_of(i));
      end
      checks++;
      if (d_wrap[i] !== 1'b0 || d_wcnt[i] !== 16'd0) begin
        errors++; $display("FAIL reset_wrap inst=%0d got wrap=%0b wcnt=%0d exp 0/0", i, d_wrap[i], d_wcnt[i]);
      end
      checks++;
      if (d_pbit[i] !== 1'(m_up[i]) || d_pint[i] !== 32'(m_t[i])) begin
        errors++; $display("FAIL reset_params inst=%0d got bit=%0b int=%h exp bit=%0d int=%h",
                           i, d_pbit[i], d_pint[i], m_up[i], m_t[i]);
      end
    end
    $display("test_reset: count/wrap/params checked on 3 instances");
  endtask

  task automatic test_up_wrap();
    do_reset();
    in_en[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (d_count[0] !== 8'(k % 19) || d_wrap[0] !== (k == 19)) begin
        errors++; $display("FAIL up_wrap cyc=%0d got count=%0d wrap=%0b exp count=%0d wrap=%0b",
                           k, d_count[0], d_wrap[0], k % 19, (k == 19));
      end
    end
    in_en[0] = 1'b0;
    checks++;
    if (d_wcnt[0] !== 16'd1) begin
      errors++; $display("FAIL up_wrap_cnt got=%0d exp=1", d_wcnt[0]);
    end
    $display("test_up_wrap: 20 enables, wrap_cnt=%0d", d_wcnt[0]);
  endtask

  task automatic test_down();
    int exp_c;
    do_reset();
    in_en[1] = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_c = (k == 19) ? 18 : 18 - k;
      checks++;
      if (d_count[1] !== 8'(exp_c) || d_wrap[1] !== (k == 19)) begin
        errors++; $display("FAIL down cyc=%0d got count=%0d wrap=%0b exp count=%0d wrap=%0b",
                           k, d_count[1], d_wrap[1], exp_c, (k == 19));
      end
    end
    in_en[1] = 1'b0;
    $display("test_down: 19 enables, wrap_cnt=%0d", d_wcnt[1]);
  endtask

  task automatic test_priority();
    do_reset();
    in_en[0] = 1'b1; in_en[1] = 1'b1;
    repeat (5) tick();
    checks++;
    if (d_count[0] !== 8'd5 || d_count[1] !== 8'd13) begin
      errors++; $display("FAIL prio_pre got up=%0d dn=%0d exp 5/13", d_count[0], d_count[1]);
    end
    for (int i = 0; i < 2; i++) begin
      in_clear[i] = 1'b1; in_load[i] = 1'b1; in_lv[i] = 8'd7; in_en[i] = 1'b1;
    end
    tick();
    checks++;
    if (d_count[0] !== 8'd0 || d_count[1] !== 8'd18 || d_wrap[0] !== 1'b0 || d_wrap[1] !== 1'b0) begin
      errors++; $display("FAIL prio_clear got up=%0d dn=%0d wraps=%0b%0b exp 0/18 00",
                         d_count[0], d_count[1], d_wrap[0], d_wrap[1]);
    end
    for (int i = 0; i < 2; i++) begin
      in_clear[i] = 1'b0; in_en[i] = 1'b0; in_load[i] = 1'b1;
    end
    in_lv[0] = 8'd200; in_lv[1] = 8'd3;
    tick();
    checks++;
    if (d_count[0] !== 8'd18 || d_count[1] !== 8'd3) begin
      errors++; $display("FAIL prio_load got up=%0d dn=%0d exp 18/3", d_count[0], d_count[1]);
    end
    in_lv[1] = 8'd255;
    in_load[0] = 1'b1; in_lv[0] = 8'd18; in_en[0] = 1'b1;
    tick();
    checks++;
    if (d_count[1] !== 8'd18 || d_count[0] !== 8'd18 || d_wrap[0] !== 1'b0) begin
      errors++; $display("FAIL prio_load_over_en got up=%0d dn=%0d wrap=%0b exp 18/18/0",
                         d_count[0], d_count[1], d_wrap[0]);
    end
    idle_inputs();
    $display("test_priority: clear>load>en and clamp checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_en[0] = 1'b1;
    repeat (28) tick();
    checks++;
    if (d_count[0] !== 8'd9 || d_wcnt[0] !== 16'd1) begin
      errors++; $display("FAIL mid_pre got count=%0d wcnt=%0d exp 9/1", d_count[0], d_wcnt[0]);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (d_count[0] !== 8'd0 || d_wrap[0] !== 1'b0 || d_wcnt[0] !== 16'd0) begin
      errors++; $display("FAIL mid_reset got count=%0d wrap=%0b wcnt=%0d exp 0/0/0",
                         d_count[0], d_wrap[0], d_wcnt[0]);
    end
    rst_n = 1'b1;
    in_en[0] = 1'b0;
    $display("test_reset_mid: reset at count=9 with en=1");
  endtask

  task automatic test_t_zero();
    do_reset();
    in_en[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (d_count[2] !== 8'd0 || d_wrap[2] !== 1'b1 || d_wcnt[2] !== 16'(k)) begin
        errors++; $display("FAIL t0 cyc=%0d got count=%0d wrap=%0b wcnt=%0d exp 0/1/%0d",
                           k, d_count[2], d_wrap[2], d_wcnt[2], k);
      end
    end
    in_en[2] = 1'b0;
    tick();
    checks++;
    if (d_wrap[2] !== 1'b0 || d_wcnt[2] !== 16'd3) begin
      errors++; $display("FAIL t0_idle got wrap=%0b wcnt=%0d exp 0/3", d_wrap[2], d_wcnt[2]);
    end
    $display("test_t_zero: 3 back-to-back wraps");
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_en[i]    = ($urandom_range(0, 3) != 0);
        in_clear[i] = ($urandom_range(0, 15) == 0);
        in_load[i]  = ($urandom_range(0, 9) == 0);
        in_lv[i]    = 8'($urandom_range(0, 255));
      end
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        bad = 0;
        checks++;
        if (d_count[i] !== 8'(m_count[i])) bad = 1;
        if (d_wrap[i] !== 1'(m_wrap[i])) bad = 1;
        if (d_wcnt[i] !== 16'(m_wcnt[i])) bad = 1;
        if (bad != 0) begin
          errors++; $display("FAIL random cyc=%0d inst=%0d got c=%0d w=%0b n=%0d exp c=%0d w=%0d n=%0d",
                             c, i, d_count[i], d_wrap[i], d_wcnt[i], m_count[i], m_wrap[i], m_wcnt[i]);
        end
      end
    end
    rst_n = 1'b1;
    idle_inputs();
    $display("test_random: 400 cycles on 3 instances");
  endtask

  task automatic test_saturation();
    do_reset();
    in_en[2] = 1'b1;
    repeat (65540) tick();
    checks++;
    if (d_wcnt[2] !== 16'hFFFF || d_wcnt[2] !== 16'(m_wcnt[2])) begin
      errors++; $display("FAIL saturate got=%h exp=ffff", d_wcnt[2]);
    end
    checks++;
    if (d_wrap[2] !== 1'b1 || d_count[2] !== 8'd0) begin
      errors++; $display("FAIL saturate_wrap got wrap=%0b count=%0d exp 1/0", d_wrap[2], d_count[2]);
    end
    in_en[2] = 1'b0;
    tick();
    $display("test_saturation: 65540 wraps, wrap_cnt=%h", d_wcnt[2]);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0; m_wrap[i] = 0; m_wcnt[i] = 0;
    end
    test_reset();
    test_up_wrap();
    test_down();
    test_priority();
    test_reset_mid();
    test_t_zero();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
